// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage enables/bubble flushes, memory-wait FSM with timeout error.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hdu_stall,
  input  logic             hdu_flush,
  input  logic             br_taken_ex,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             en_pc,
  output logic             en_if_id,
  output logic             en_id_ex,
  output logic             en_ex_mem,
  output logic             en_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_timeout_q, mem_timeout_d;
  logic                freeze;
  logic                mem_stall;
  logic [4:0]          core_en;
  logic [1:0]          core_fl;

  assign mem_stall = dmem_req & ~dmem_ready;
  assign freeze    = (state_q == ERR) | mem_stall;

  // Enables/flushes ignoring reset; reset override is applied at the ports.
  always_comb begin
    core_en = 5'b11111;
    core_fl = 2'b00;
    if (freeze) begin
      core_en = 5'b00000;
    end else if (br_taken_ex) begin
      core_fl = 2'b11;
    end else if (hdu_stall | hdu_flush) begin
      core_en = 5'b00111;
      core_fl = 2'b01;
    end
  end

  assign en_pc       = ~rst & core_en[4];
  assign en_if_id    = ~rst & core_en[3];
  assign en_id_ex    = ~rst & core_en[2];
  assign en_ex_mem   = ~rst & core_en[1];
  assign en_mem_wb   = ~rst & core_en[0];
  assign flush_if_id = rst | core_fl[1];
  assign flush_id_ex = rst | core_fl[0];
  assign mem_timeout = mem_timeout_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready | ~dmem_req) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
            state_d = ERR;
          end
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
    mem_timeout_d = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!core_en[4] && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (br_taken_ex && !freeze && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the priority rules, timeout and counters.
module tb_pipe_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;
  localparam longint CNT_MAX = (64'sd1 <<< CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hdu_stall = 1'b0, hdu_flush = 1'b0, br_taken_ex = 1'b0;
  logic dmem_req = 1'b0, dmem_ready = 1'b0;
  logic en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic flush_if_id, flush_id_ex, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .hdu_stall(hdu_stall), .hdu_flush(hdu_flush), .br_taken_ex(br_taken_ex),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .en_pc(en_pc), .en_if_id(en_if_id), .en_id_ex(en_id_ex),
    .en_ex_mem(en_ex_mem), .en_mem_wb(en_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: error flag, length of the current run of not-ready cycles, counters.
  bit     m_err;
  int     m_nr;
  longint m_stall, m_flush;

  function automatic longint exp_cnt(longint v);
`ifdef PIPE_CTRL_PERF_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_err = 0; m_nr = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_freeze();
    return m_err || (dmem_req && !dmem_ready);
  endfunction

  function automatic logic [4:0] m_en();
    if (m_freeze()) return 5'b00000;
    if (br_taken_ex) return 5'b11111;
    if (hdu_stall || hdu_flush) return 5'b00111;
    return 5'b11111;
  endfunction

  function automatic logic [1:0] m_fl();
    if (m_freeze()) return 2'b00;
    if (br_taken_ex) return 2'b11;
    if (hdu_stall || hdu_flush) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_outputs(input string tag, input bit in_rst);
    logic [4:0] e_en;
    logic [1:0] e_fl;
    e_en = in_rst ? 5'b00000 : m_en();
    e_fl = in_rst ? 2'b11 : m_fl();
    check({tag, "/en"}, 64'({en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb}), 64'(e_en));
    check({tag, "/flush"}, 64'({flush_if_id, flush_id_ex}), 64'(e_fl));
    check({tag, "/mem_timeout"}, 64'(mem_timeout), 64'(m_err));
    check({tag, "/stall_cnt"}, 64'(stall_cnt), 64'(exp_cnt(m_stall)));
    check({tag, "/flush_cnt"}, 64'(flush_cnt), 64'(exp_cnt(m_flush)));
  endtask

  task automatic model_clock();
    bit fz;
    fz = m_freeze();
    if (m_en() == 5'b00000 || m_en() == 5'b00111)
      m_stall = (m_stall == CNT_MAX) ? m_stall : m_stall + 1;
    if (br_taken_ex && !fz)
      m_flush = (m_flush == CNT_MAX) ? m_flush : m_flush + 1;
    if (!m_err) begin
      if (dmem_req && !dmem_ready) begin
        m_nr++;
        if (m_nr == TIMEOUT) m_err = 1;
      end else begin
        m_nr = 0;
      end
    end
  endtask

  // Called one time unit after a posedge; returns one time unit after the next.
  task automatic step(input logic hs, input logic hf, input logic br,
                      input logic req, input logic rdy, input string tag);
    hdu_stall = hs; hdu_flush = hf; br_taken_ex = br; dmem_req = req; dmem_ready = rdy;
    #2;
    check_outputs(tag, 1'b0);
    $display("cycle %s: hs=%0b br=%0b req=%0b rdy=%0b en=%b fl=%b to=%0b sc=%0d fc=%0d", tag,
             hs, br, req, rdy, {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb},
             {flush_if_id, flush_id_ex}, mem_timeout, stall_cnt, flush_cnt);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  // Reset raised between clock edges, held across one edge, then released.
  task automatic apply_rst(input string tag);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_outputs({tag, "/async"}, 1'b1);
    @(posedge clk);
    #1;
    check_outputs({tag, "/held"}, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    check_outputs("reset", 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;

    step(0, 0, 0, 0, 0, "idle0");
    step(0, 0, 0, 0, 0, "idle1");

    step(1, 1, 0, 0, 0, "loaduse");
    step(0, 0, 0, 0, 0, "after_loaduse");
    step(1, 1, 1, 0, 0, "br_over_stall");
    step(0, 0, 0, 0, 0, "after_br");

    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, "memwait");
    step(0, 0, 1, 1, 1, "memready");
    step(0, 0, 0, 0, 0, "after_mem0");
    step(0, 0, 0, 0, 0, "after_mem1");

    for (int i = 0; i < TIMEOUT + 2; i++) step(0, 0, 0, 1, 0, "timeout");
    step(0, 0, 0, 1, 1, "err_ready");
    step(0, 0, 1, 0, 0, "err_idle");
    apply_rst("rst_err");
    step(0, 0, 0, 0, 0, "post_err_idle");

    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, "wait_then_rst");
    apply_rst("rst_wait");
    step(0, 0, 0, 1, 1, "zero_stall");
    step(0, 0, 0, 0, 0, "zero_stall_after");

    for (int i = 0; i < 400; i++) begin
      logic hs, br, req, rdy;
      hs  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 4) == 0);
      req = ($urandom_range(0, 2) == 0) || (i >= 250);
      rdy = (i < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 59) == 0) apply_rst("rand_rst");
      else step(hs, hs, br, req, rdy, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
